// File: rtl/mc_controller.sv
// Multicycle control unit: main FSM, ALU decoder and conditional execution.
// Drives datapath selects/enables and holds the architectural NZCV flags.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        ir_w, next_pc, branch;
  logic        reg_w, mem_w, alu_op;
  logic        known;
  logic [1:0]  flag_w;
  logic        no_write, pcs;
  logic [3:0]  flags;
  logic        n, z, c, v;
  logic        cond_ex, cond_ex_reg;
  logic        unused;

  assign cond   = Instr[31:28];
  assign op     = Instr[27:26];
  assign funct  = Instr[25:20];
  assign rd     = Instr[15:12];
  assign unused = ^{Instr[19:16], Instr[11:0]};

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = FETCH;
    ir_w      = 1'b0;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        state_n   = DECODE;
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_n = funct[5] ? EXECUTEI
                                      : EXECUTER;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_n = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_n = MEMWB;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      EXECUTER: begin
        alu_op  = 1'b1;
        state_n = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_n = ALUWB;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    known      = 1'b0;
    flag_w     = 2'b00;
    if (alu_op) begin
      known = 1'b1;
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: known      = 1'b0;
      endcase
      flag_w[1] = known & funct[0];
      flag_w[0] = known & funct[0]
                & ~ALUControl[1];
    end
  end

  // CMP is recognised in ALUWB too, where the ALU decoder is idle
  assign no_write = (op == 2'b00)
                  & (funct[4:1] == 4'b1010);

  assign {n, z, c, v} = flags;

  always_comb begin
    case (cond)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = ~z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = ~c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = ~n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = ~v;
      4'h8:    cond_ex = c & ~z;
      4'h9:    cond_ex = ~(c & ~z);
      4'hA:    cond_ex = (n == v);
      4'hB:    cond_ex = (n != v);
      4'hC:    cond_ex = ~z & (n == v);
      4'hD:    cond_ex = z | (n != v);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      cond_ex_reg <= cond_ex;
      if (flag_w[1] & cond_ex)
        flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex)
        flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs = ((rd == 4'hF) & reg_w) | branch;

  // Enables are held off for the whole reset window
  assign PCWrite  = reset
                  & ((pcs & cond_ex_reg) | next_pc);
  assign IRWrite  = reset & ir_w;
  assign RegWrite = reset & reg_w & cond_ex_reg
                  & ~no_write;
  assign MemWrite = reset & mem_w & cond_ex_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle vector table plus
// hand-written reset sequences.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, RegWrite, MemWrite;
  logic        AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [1:0]  ALUControl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset),
    .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  fl;
    logic [3:0]  st;
    logic [3:0]  en;
    logic        adr;
    logic        srca;
    logic [1:0]  srcb;
    logic [1:0]  res;
    logic [1:0]  aluc;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rsrc(logic [31:0] i);
    logic [1:0] o;
    o = i[27:26];
    case (o)
      2'b00:   return {o, 2'b00};
      2'b01:   return {o, 2'b10};
      2'b10:   return {o, 2'b01};
      default: return {o, 2'b00};
    endcase
  endfunction

  task automatic row(logic [31:0] i, logic [3:0] fl,
                     logic [3:0] st, logic [3:0] en,
                     logic adr, logic sa,
                     logic [1:0] sb, logic [1:0] rs,
                     logic [1:0] ac, logic [3:0] f);
    vec_t r;
    r.instr = i;  r.fl = fl;  r.st = st;
    r.en = en;    r.adr = adr; r.srca = sa;
    r.srcb = sb;  r.res = rs;  r.aluc = ac;
    r.flags = f;
    tbl.push_back(r);
  endtask

  function automatic logic [3:0] enables();
    return {PCWrite, IRWrite, RegWrite, MemWrite};
  endfunction

  localparam logic [31:0] ADD  = 32'hE0812003;
  localparam logic [31:0] ADDP = 32'hE081F003;
  localparam logic [31:0] SUBS = 32'hE0523003;
  localparam logic [31:0] BEQ  = 32'h0A000002;
  localparam logic [31:0] BNE  = 32'h1A000002;
  localparam logic [31:0] LDR  = 32'hE5912004;
  localparam logic [31:0] STNE = 32'h15812004;
  localparam logic [31:0] UND  = 32'hEC000000;
  localparam logic [31:0] CMP  = 32'hE1520003;
  localparam logic [31:0] STR  = 32'hE5812004;

  initial begin
    reset    = 1'b0;
    Instr    = ADD;
    ALUFlags = 4'b0000;

    // vectors: instr, ALUFlags, state, {PCW,IRW,RegW,MemW},
    // AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, flags
    row(ADD, 4'hF, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h0);
    row(ADD, 4'hF, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h0);
    row(ADD, 4'hF, 6, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
    row(ADD, 4'hF, 8, 4'b0010, 0, 0, 0, 0, 0, 4'h0);
    row(ADDP, 4'hF, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h0);
    row(ADDP, 4'hF, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h0);
    row(ADDP, 4'hF, 6, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
    row(ADDP, 4'hF, 8, 4'b1010, 0, 0, 0, 0, 0, 4'h0);
    row(SUBS, 4'h6, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h0);
    row(SUBS, 4'h6, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h0);
    row(SUBS, 4'h6, 6, 4'b0000, 0, 0, 0, 0, 1, 4'h0);
    row(SUBS, 4'h6, 8, 4'b0010, 0, 0, 0, 0, 0, 4'h6);
    row(BEQ, 4'h0, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h6);
    row(BEQ, 4'h0, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h6);
    row(BEQ, 4'h0, 9, 4'b1000, 0, 0, 1, 2, 0, 4'h6);
    row(BNE, 4'h0, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h6);
    row(BNE, 4'h0, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h6);
    row(BNE, 4'h0, 9, 4'b0000, 0, 0, 1, 2, 0, 4'h6);
    row(LDR, 4'h0, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h6);
    row(LDR, 4'h0, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h6);
    row(LDR, 4'h0, 2, 4'b0000, 0, 0, 1, 0, 0, 4'h6);
    row(LDR, 4'h0, 3, 4'b0000, 1, 0, 0, 0, 0, 4'h6);
    row(LDR, 4'h0, 4, 4'b0010, 0, 0, 0, 1, 0, 4'h6);
    row(STNE, 4'h0, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h6);
    row(STNE, 4'h0, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h6);
    row(STNE, 4'h0, 2, 4'b0000, 0, 0, 1, 0, 0, 4'h6);
    row(STNE, 4'h0, 5, 4'b0000, 1, 0, 0, 0, 0, 4'h6);
    row(UND, 4'h0, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h6);
    row(UND, 4'h0, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h6);
    row(CMP, 4'h9, 0, 4'b1100, 0, 1, 2, 2, 0, 4'h6);
    row(CMP, 4'h9, 1, 4'b0000, 0, 1, 2, 2, 0, 4'h6);
    row(CMP, 4'h9, 6, 4'b0000, 0, 0, 0, 0, 1, 4'h6);
    row(CMP, 4'h9, 8, 4'b0000, 0, 0, 0, 0, 0, 4'h9);

    // reset held for three cycles
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_en", 32'(enables()), 32'h0);
      check("rst_state", 32'(dut.state), 32'h0);
      check("rst_flags", 32'(dut.flags), 32'h0);
      check("rst_cexr", 32'(dut.cond_ex_reg), 32'h0);
      check("rst_srcb", 32'(ALUSrcB), 32'h2);
      tick();
    end
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      Instr    = tbl[i].instr;
      ALUFlags = tbl[i].fl;
      #1;
      check($sformatf("v%0d_state", i),
            32'(dut.state), 32'(tbl[i].st));
      check($sformatf("v%0d_en", i),
            32'(enables()), 32'(tbl[i].en));
      check($sformatf("v%0d_sel", i),
            32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                 ImmSrc, RegSrc}),
            32'({tbl[i].adr, tbl[i].srca, tbl[i].srcb,
                 tbl[i].res, rsrc(tbl[i].instr)}));
      check($sformatf("v%0d_aluc", i),
            32'(ALUControl), 32'(tbl[i].aluc));
      check($sformatf("v%0d_flags", i),
            32'(dut.flags), 32'(tbl[i].flags));
      tick();
    end

    // reset asserted mid-store, in MEMADR
    Instr    = STR;
    ALUFlags = 4'h0;
    #1;
    check("str_fetch", 32'(dut.state), 32'h0);
    tick();
    tick();
    check("str_memadr", 32'(dut.state), 32'h2);
    check("str_flags", 32'(dut.flags), 32'h9);
    reset = 1'b0;
    #1;
    check("abort_state", 32'(dut.state), 32'h0);
    check("abort_flags", 32'(dut.flags), 32'h0);
    check("abort_en", 32'(enables()), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("abort_hold_en", 32'(enables()), 32'h0);
      check("abort_hold_st", 32'(dut.state), 32'h0);
    end
    reset = 1'b1;
    #1;
    check("rel_en", 32'(enables()), 32'hC);
    tick();
    check("rel_decode", 32'(dut.state), 32'h1);
    tick();
    check("rel_memadr", 32'(dut.state), 32'h2);
    tick();
    check("rel_memwr", 32'(dut.state), 32'h5);
    check("rel_memw", 32'(MemWrite), 32'h1);
    tick();
    check("rel_back", 32'(dut.state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
